error_sampler: RTL and testbench
================================

// Module: error_sampler
// PURPOSE
// - Upstream stage of the PI/PID loop: on each sample strobe, requests one ADC conversion and captures the
//   measurement y(k).
// - Computes e(k) = ref - y(k), saturated to W-bit two's complement, and registers it.
// - e(k) feeds the integrator's ek input; the one-cycle en_out pulse drives that integrator's Enable.
// - Also holds e(k-1) for the derivative path.
// PARAMETERS
// - W        19  width of ref, ek, ek_1 (two's complement, same fixed-point format as the integrator)
// - N        12  ADC sample width (unsigned)
// - SHIFT     6  left shift that aligns the ADC sample into the W-bit format (requires N+SHIFT <= W-1)
// - TIMEOUT  16  maximum cycles spent waiting for adc_valid before aborting
// - DEADBAND 64  |e| below this is forced to 0 (used only with ERROR_DEADBAND_EN)
// PORTS
// - CLK        in   1  system clock, rising edge
// - Reset      in   1  asynchronous, active-low reset
// - Start      in   1  sample strobe; one-cycle pulse from the loop timing block
// - ref        in   W  setpoint; sampled in CALC
// - adc_data   in   N  ADC result; valid only when adc_valid=1
// - adc_valid  in   1  ADC result strobe
// - adc_req    out  1  conversion request; high for the whole REQ state
// - ek         out  W  registered error e(k)
// - ek_1       out  W  registered previous error e(k-1)
// - en_out     out  1  one-cycle pulse; ek/ek_1 are new and stable; connects to the integrator Enable
// - sat        out  1  registered; 1 when the latest ek was clamped
// - timeout    out  1  one-cycle pulse; the ADC did not answer within TIMEOUT cycles
// - busy       out  1  state != IDLE
// BEHAVIOUR
// - Reset (Reset=0, at any time, async) does all of:
//   - state=IDLE
//   - ek, ek_1, adc_latch, wait counter = 0
//   - all 1-bit outputs = 0
//   - an in-flight sample is discarded
// - FSM, registered; outputs decode from the state register:
//   - IDLE: Start=1 -> REQ and clear the wait counter; otherwise stay.
//   - REQ: adc_req=1.
//     - adc_valid=1 -> latch adc_data, then CALC.
//     - counter==TIMEOUT-1 with no valid -> IDLE, pulse timeout; ek/ek_1 are left unchanged.
//     - Otherwise increment the counter.
//   - CALC: d = sext(ref, W+1) - zext(adc_latch << SHIFT, W+1).
//     - d > 2^(W-1)-1 -> clamp to 2^(W-1)-1. d < -2^(W-1) -> clamp to -2^(W-1). Either clamp sets sat=1.
//     - Update ek_1 <= ek and ek <= clamped d. State -> DONE.
//   - DONE: en_out=1 for exactly this one cycle -> IDLE.
// - Latency: Start seen at edge t gives adc_req during t..t+k (valid at edge t+k), CALC in t+k..t+k+1,
//   and en_out in the cycle after edge t+k+1.
// - Start while busy=1 is ignored; there is no queueing.
// - adc_valid outside REQ is ignored.
// - Start and adc_valid in the same IDLE cycle: only the Start is taken; that adc_valid does not count.
// - ek/ek_1 change only at the CALC->DONE edge. They hold between samples and hold through a timeout.
// CONFIGURATION
// - ERROR_DEADBAND_EN defined: in CALC, after clamping, |d| < DEADBAND forces ek=0 (sat is unaffected).
// - ERROR_DEADBAND_EN undefined: no deadband; DEADBAND is unused.
// STRUCTURE
// - Shared package pid_pkg:
//   - state enum (IDLE, REQ, CALC, DONE)
//   - W_DEF=19
//   - saturation constants MAX_W / MIN_W as functions of W
// - Sub-module sub_saturado: combinational W+1-bit subtract plus clamp.
//   - Outputs the W-bit result and the sat flag.
//   - Reusable by the loop's P+I+D summing stage.
// TESTING (W=19, N=12, SHIFT=6, TIMEOUT=16, DEADBAND=64)
// - Nominal: ref=20000, adc_data=0x100 (16384) -> ek=3616, sat=0, en_out one cycle after CALC, ek_1=0.
// - Second sample: ref=20000, adc_data=0x140 (20480) -> ek=-480, ek_1=3616.
// - Saturation: ref=-262144, adc_data=0xFFF (262080) -> ek=-262144, sat=1.
//   - Also: ref=262143, adc_data=0 -> ek=262143, sat=0.
// - Timeout: Start, adc_valid held 0 -> timeout pulse 16 cycles after REQ entry; en_out never; ek unchanged.
// - Start while busy and reset mid-REQ:
//   - Extra Start pulses while busy -> exactly one en_out.
//   - Reset=0 during REQ -> adc_req=0 immediately, ek=0, state IDLE.
// - Deadband (ERROR_DEADBAND_EN defined): ref=16424, adc_data=0x100 (d=40) -> ek=0.
//   - Without the macro, the same stimulus -> ek=40.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared state encoding, default width and saturation limits for the PID loop stages
package pid_pkg;
  localparam int W_DEF = 19;
  typedef enum logic [1:0] {IDLE, REQ, CALC, DONE} state_e;
  function automatic longint max_w(int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
  function automatic longint min_w(int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/error_sampler_if.sv
// error_sampler_if: sample strobe, setpoint, ADC handshake and error outputs of the error sampler
interface error_sampler_if #(
  parameter int W = 19,
  parameter int N = 12
);
  logic         start_i;
  logic [W-1:0] ref_i;
  logic [N-1:0] adc_data_i;
  logic         adc_valid_i;
  logic         adc_req_o;
  logic [W-1:0] ek_o;
  logic [W-1:0] ek_1_o;
  logic         en_out_o;
  logic         sat_o;
  logic         timeout_o;
  logic         busy_o;
  modport slave (
    input  start_i, ref_i, adc_data_i, adc_valid_i,
    output adc_req_o, ek_o, ek_1_o, en_out_o, sat_o, timeout_o, busy_o
  );
  modport master (
    output start_i, ref_i, adc_data_i, adc_valid_i,
    input  adc_req_o, ek_o, ek_1_o, en_out_o, sat_o, timeout_o, busy_o
  );
endinterface

// File: rtl/sub_saturado.sv
// sub_saturado: W+1-bit signed subtract a-b clamped back to W bits, with a clamp flag
module sub_saturado
  import pid_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         sat_o
);
  localparam logic [W-1:0] MAX = W'(max_w(W));
  localparam logic [W-1:0] MIN = W'(min_w(W));
  logic [W:0] d;
  // the extra bit disagreeing with the W-bit sign means the result left the W-bit range
  always_comb begin
    d     = {a_i[W-1], a_i} - {b_i[W-1], b_i};
    sat_o = d[W] ^ d[W-1];
    y_o   = sat_o ? (d[W] ? MIN : MAX) : d[W-1:0];
  end
endmodule

// File: rtl/error_sampler.sv
// error_sampler: per-strobe ADC capture and saturated error e(k)=ref-y(k); ERROR_DEADBAND_EN zeroes small errors
module error_sampler
  import pid_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int N        = 12,
  parameter int SHIFT    = 6,
  parameter int TIMEOUT  = 16,
  parameter int DEADBAND = 64
) (
  input logic      clk,
  input logic      rst_n,
  error_sampler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [W-1:0] DB = W'(DEADBAND);
`ifdef ERROR_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  latch_q, latch_d;
  logic [W-1:0]  ek_q, ek_d, ek1_q, ek1_d;
  logic          sat_q, sat_d, to_q, to_d;
  logic [W-1:0]  y_w, res;
  logic signed [W-1:0] res_s;
  logic          res_sat, dead;
  assign y_w = {{(W-N-SHIFT){1'b0}}, latch_q, {SHIFT{1'b0}}};
  sub_saturado #(.W(W)) u_sub (
    .a_i  (bus.ref_i),
    .b_i  (y_w),
    .y_o  (res),
    .sat_o(res_sat)
  );
  // deadband applies after clamping and never touches the sat flag
  always_comb begin
    res_s = res;
    dead  = DB_EN && (res_s < DB) && (res_s > -DB);
  end
  // next-state: strobe -> request -> compute -> publish, with a bounded ADC wait
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    ek_d    = ek_q;
    ek1_d   = ek1_q;
    sat_d   = sat_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.start_i) begin
        state_d = REQ;
        cnt_d   = '0;
      end
      REQ: if (bus.adc_valid_i) begin
        latch_d = bus.adc_data_i;
        state_d = CALC;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      CALC: begin
        ek1_d   = ek_q;
        ek_d    = dead ? '0 : res;
        sat_d   = res_sat;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset drops any in-flight sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      latch_q <= '0;
      ek_q    <= '0;
      ek1_q   <= '0;
      sat_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      ek_q    <= ek_d;
      ek1_q   <= ek1_d;
      sat_q   <= sat_d;
      to_q    <= to_d;
    end
  end
  assign bus.adc_req_o = state_q == REQ;
  assign bus.en_out_o  = state_q == DONE;
  assign bus.busy_o    = state_q != IDLE;
  assign bus.ek_o      = ek_q;
  assign bus.ek_1_o    = ek1_q;
  assign bus.sat_o     = sat_q;
  assign bus.timeout_o = to_q;
endmodule

// File: tb/tb_error_sampler.sv
// tb_error_sampler: randomized and directed checks of error_sampler against an arithmetic reference model
module tb_error_sampler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  logic [18:0] exp_ek = '0;
  logic [18:0] exp_ek1 = '0;
  logic        exp_sat = 1'b0;

  error_sampler_if #(.W(19), .N(12)) bus ();
  error_sampler #(.W(19), .N(12), .SHIFT(6), .TIMEOUT(16), .DEADBAND(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] model(int r, int a);
    int d;
    logic s;
    d = r - a * 64;
    s = 1'b0;
    if (d > 262143) begin d = 262143; s = 1'b1; end
    else if (d < -262144) begin d = -262144; s = 1'b1; end
`ifdef ERROR_DEADBAND_EN
    if (d > -64 && d < 64) d = 0;
`endif
    return {s, d[18:0]};
  endfunction

  task automatic sample(input string nm, input int r, input int a, input int k);
    logic [19:0] m;
    @(negedge clk); bus.start_i = 1'b1; bus.ref_i = 19'(r);
    @(negedge clk); bus.start_i = 1'b0;
    total++; if (bus.adc_req_o !== 1'b1) $display("FAIL %s req: adc_req=%b want 1", nm, bus.adc_req_o); else pass_cnt++;
    repeat (k - 1) @(negedge clk);
    bus.adc_valid_i = 1'b1; bus.adc_data_i = 12'(a);
    @(negedge clk); bus.adc_valid_i = 1'b0; bus.adc_data_i = 12'($urandom);
    total++;
    if ({bus.adc_req_o, bus.en_out_o, bus.busy_o, bus.ek_o} !== {3'b001, exp_ek})
      $display("FAIL %s calc: req/en/busy=%b%b%b ek=%0d want 001 ek=%0d", nm, bus.adc_req_o, bus.en_out_o, bus.busy_o, bus.ek_o, exp_ek);
    else pass_cnt++;
    @(negedge clk);
    m = model(r, a); exp_ek1 = exp_ek; exp_ek = m[18:0]; exp_sat = m[19];
    total++;
    if ({bus.en_out_o, bus.ek_o, bus.ek_1_o, bus.sat_o} !== {1'b1, exp_ek, exp_ek1, exp_sat})
      $display("FAIL %s done: en=%b ek=%0d ek_1=%0d sat=%b want en=1 ek=%0d ek_1=%0d sat=%b", nm, bus.en_out_o, $signed(bus.ek_o), $signed(bus.ek_1_o), bus.sat_o, $signed(exp_ek), $signed(exp_ek1), exp_sat);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({bus.en_out_o, bus.busy_o, bus.ek_o} !== {2'b00, exp_ek})
      $display("FAIL %s after: en=%b busy=%b ek=%0d want 0 0 %0d", nm, bus.en_out_o, bus.busy_o, bus.ek_o, exp_ek);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.start_i = 0; bus.ref_i = '0; bus.adc_data_i = '0; bus.adc_valid_i = 0;
    rst_n = 1'b0;
    #12;
    total++;
    if ({bus.adc_req_o, bus.en_out_o, bus.sat_o, bus.timeout_o, bus.busy_o, bus.ek_o, bus.ek_1_o} !== 43'd0)
      $display("FAIL reset: req/en/sat/to/busy=%b%b%b%b%b ek=%0d ek_1=%0d want all 0", bus.adc_req_o, bus.en_out_o, bus.sat_o, bus.timeout_o, bus.busy_o, bus.ek_o, bus.ek_1_o);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    sample("nominal", 20000, 'h100, 2);
    total++; if (bus.ek_o !== 19'd3616 || bus.ek_1_o !== 19'd0) $display("FAIL nominal_const: ek=%0d ek_1=%0d want 3616 0", bus.ek_o, bus.ek_1_o); else pass_cnt++;
    sample("second", 20000, 'h140, 1);
    total++; if (bus.ek_o !== 19'(-480) || bus.ek_1_o !== 19'd3616) $display("FAIL second_const: ek=%0d ek_1=%0d want -480 3616", $signed(bus.ek_o), bus.ek_1_o); else pass_cnt++;
  endtask

  task automatic test_saturation();
    sample("sat_neg", -262144, 'hFFF, 3);
    total++; if (bus.ek_o !== 19'h40000 || bus.sat_o !== 1'b1) $display("FAIL sat_neg_const: ek=%0d sat=%b want -262144 1", $signed(bus.ek_o), bus.sat_o); else pass_cnt++;
    sample("sat_pos", 262143, 0, 1);
    total++; if (bus.ek_o !== 19'h3FFFF || bus.sat_o !== 1'b0) $display("FAIL sat_pos_const: ek=%0d sat=%b want 262143 0", bus.ek_o, bus.sat_o); else pass_cnt++;
  endtask

  task automatic test_deadband();
    sample("deadband", 16424, 'h100, 2);
`ifdef ERROR_DEADBAND_EN
    total++; if (bus.ek_o !== 19'd0) $display("FAIL deadband_const: ek=%0d want 0", bus.ek_o); else pass_cnt++;
`else
    total++; if (bus.ek_o !== 19'd40) $display("FAIL deadband_const: ek=%0d want 40", bus.ek_o); else pass_cnt++;
`endif
  endtask

  task automatic test_timeout();
    int n;
    int en_seen;
    @(negedge clk); bus.start_i = 1'b1; bus.ref_i = 19'd1234;
    @(negedge clk); bus.start_i = 1'b0;
    n = 0; en_seen = 0;
    while (bus.timeout_o !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (bus.en_out_o === 1'b1) en_seen++;
      if (n == 15) begin
        total++; if (bus.adc_req_o !== 1'b1) $display("FAIL timeout_req: adc_req=%b want 1 at cycle 15", bus.adc_req_o); else pass_cnt++;
      end
    end
    total++; if (n != 16) $display("FAIL timeout_latency: got %0d cycles want 16", n); else pass_cnt++;
    total++;
    if ({bus.adc_req_o, bus.busy_o, bus.ek_o, bus.ek_1_o} !== {2'b00, exp_ek, exp_ek1} || en_seen != 0)
      $display("FAIL timeout_state: req=%b busy=%b ek=%0d ek_1=%0d en_seen=%0d want 0 0 %0d %0d 0", bus.adc_req_o, bus.busy_o, bus.ek_o, bus.ek_1_o, en_seen, exp_ek, exp_ek1);
    else pass_cnt++;
    @(negedge clk);
    total++; if (bus.timeout_o !== 1'b0) $display("FAIL timeout_pulse: timeout=%b want 0", bus.timeout_o); else pass_cnt++;
  endtask

  task automatic test_ignore_valid();
    int bad;
    bad = 0;
    bus.adc_valid_i = 1'b1; bus.adc_data_i = 12'h7;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b0 || bus.en_out_o !== 1'b0) bad++;
    end
    bus.adc_valid_i = 1'b0;
    total++; if (bad != 0 || bus.ek_o !== exp_ek) $display("FAIL idle_valid: bad=%0d ek=%0d want 0 %0d", bad, bus.ek_o, exp_ek); else pass_cnt++;
  endtask

  task automatic test_start_valid_same();
    logic [19:0] m;
    @(negedge clk); bus.start_i = 1'b1; bus.ref_i = 19'd5000; bus.adc_valid_i = 1'b1; bus.adc_data_i = 12'h3;
    @(negedge clk); bus.start_i = 1'b0; bus.adc_valid_i = 1'b0;
    @(negedge clk);
    total++; if (bus.adc_req_o !== 1'b1) $display("FAIL start_valid_same: adc_req=%b want 1", bus.adc_req_o); else pass_cnt++;
    bus.adc_valid_i = 1'b1; bus.adc_data_i = 12'h10;
    @(negedge clk); bus.adc_valid_i = 1'b0;
    @(negedge clk);
    m = model(5000, 'h10); exp_ek1 = exp_ek; exp_ek = m[18:0]; exp_sat = m[19];
    total++;
    if ({bus.en_out_o, bus.ek_o, bus.ek_1_o} !== {1'b1, exp_ek, exp_ek1})
      $display("FAIL start_valid_data: en=%b ek=%0d ek_1=%0d want 1 %0d %0d", bus.en_out_o, bus.ek_o, bus.ek_1_o, exp_ek, exp_ek1);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_busy_start();
    int en_cnt;
    logic [19:0] m;
    en_cnt = 0;
    @(negedge clk); bus.start_i = 1'b1; bus.ref_i = 19'd7777; bus.adc_data_i = 12'h50;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.en_out_o === 1'b1) en_cnt++;
      bus.start_i = (bus.busy_o === 1'b1) ? 1'($urandom) | (i < 2) : 1'b0;
      bus.adc_valid_i = (i == 3);
    end
    bus.start_i = 1'b0;
    m = model(7777, 'h50); exp_ek1 = exp_ek; exp_ek = m[18:0]; exp_sat = m[19];
    total++; if (en_cnt != 1) $display("FAIL busy_start_count: en_out pulses=%0d want 1", en_cnt); else pass_cnt++;
    total++; if (bus.ek_o !== exp_ek || bus.ek_1_o !== exp_ek1) $display("FAIL busy_start_data: ek=%0d ek_1=%0d want %0d %0d", bus.ek_o, bus.ek_1_o, exp_ek, exp_ek1); else pass_cnt++;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(524287)) - 262144;
      sample("random", r, int'($urandom_range(4095)), int'($urandom_range(5, 1)));
    end
  endtask

  task automatic test_reset_mid_req();
    int en_cnt;
    en_cnt = 0;
    @(negedge clk); bus.start_i = 1'b1; bus.ref_i = 19'd100;
    @(negedge clk); bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.adc_req_o, bus.busy_o, bus.sat_o, bus.ek_o, bus.ek_1_o} !== 41'd0)
      $display("FAIL reset_mid_req: req=%b busy=%b sat=%b ek=%0d ek_1=%0d want all 0", bus.adc_req_o, bus.busy_o, bus.sat_o, bus.ek_o, bus.ek_1_o);
    else pass_cnt++;
    exp_ek = '0; exp_ek1 = '0; exp_sat = 1'b0;
    bus.adc_valid_i = 1'b1; bus.adc_data_i = 12'h20;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus.adc_valid_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.en_out_o === 1'b1 || bus.busy_o === 1'b1) en_cnt++;
    end
    total++; if (en_cnt != 0 || bus.ek_o !== 19'd0) $display("FAIL reset_discard: activity=%0d ek=%0d want 0 0", en_cnt, bus.ek_o); else pass_cnt++;
    sample("post_reset", 3000, 'h20, 2);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_deadband();
    test_timeout();
    test_ignore_valid();
    test_start_valid_same();
    test_busy_start();
    test_random();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
